// File: rtl/pll_ctrl_pkg.sv
// PLL lock sequencer shared types.
// State encoding and bundle widths.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  localparam int RETRY_W    = 8;
  localparam int LOSS_CNT_W = 16;

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single CDC bit.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on refclk; gates sys_rst.
// Optional PLL_LOCK_LOSS_CNT_EN adds loss_cnt output.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               fault_clr,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ?
                         RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ?
                         MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  pll_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               pll_rst_d, sys_rst_d;
  logic               ready_d, fault_d;
  logic               lk;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  // next state, shared counter, retry count, output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST)
          state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ?
                    FAULT : PLL_RESET;
        end
      end
      STABLE: begin
        if (!lk)
          state_d = WAIT_LOCK;
        else if (cnt_q == ST_LAST)
          state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lk)
          state_d = PLL_RESET;
      end
      FAULT: begin
        cnt_d = '0;
        if (fault_clr) begin
          state_d = PLL_RESET;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
    if (state_d != state_q)
      cnt_d = '0;
    if (state_d == RUN && state_q != RUN)
      retry_d = '0;
    pll_rst_d = (state_d == PLL_RESET) ||
                (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  // state, counter and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= PLL_RESET;
      cnt_q   <= '0;
      retry_q <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pll_rst <= pll_rst_d;
      sys_rst <= sys_rst_d;
      ready   <= ready_d;
      fault   <= fault_d;
    end
  end

  assign retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  // saturating count of lock losses while running
  always_ff @(posedge refclk) begin
    if (rst)
      loss_cnt <= '0;
    else if (state_q == RUN && state_d == PLL_RESET &&
             loss_cnt != '1)
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer.
// Vector table with a cycle-tagged scoreboard.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       fault_clr;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .fault_clr  (fault_clr),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  always #10 refclk = ~refclk;

  typedef struct {
    logic        r;
    logic        p;
    logic        c;
    int          n;
    logic        pr;
    logic        sr;
    logic        rd;
    logic        ft;
    logic [7:0]  rc;
    logic [15:0] lc;
  } vec_t;

  typedef struct {
    int   cyc;
    int   idx;
    vec_t e;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  sb_t  cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic add(
    input logic r, input logic p, input logic c,
    input int n,
    input logic pr, input logic sr,
    input logic rd, input logic ft,
    input int rc, input int lc
  );
    vec_t v;
    v.r = r; v.p = p; v.c = c; v.n = n;
    v.pr = pr; v.sr = sr; v.rd = rd; v.ft = ft;
    v.rc = 8'(rc); v.lc = 16'(lc);
    tbl.push_back(v);
  endtask

  always @(posedge refclk) cyc <= cyc + 1;

  // scoreboard: compare entries due at this cycle
  always @(negedge refclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      n_chk++;
      if (cur.cyc == cyc &&
          pll_rst == cur.e.pr && sys_rst == cur.e.sr &&
          ready == cur.e.rd && fault == cur.e.ft &&
          retry_cnt == cur.e.rc)
        n_pass++;
      else
        $display(
          "FAIL vec%0d cyc%0d got pr%b sr%b rd%b ft%b rc%0d exp pr%b sr%b rd%b ft%b rc%0d",
          cur.idx, cyc, pll_rst, sys_rst, ready,
          fault, retry_cnt, cur.e.pr, cur.e.sr,
          cur.e.rd, cur.e.ft, cur.e.rc);
`ifdef PLL_LOCK_LOSS_CNT_EN
      n_chk++;
      if (loss_cnt == cur.e.lc)
        n_pass++;
      else
        $display("FAIL loss vec%0d got %0d exp %0d",
                 cur.idx, loss_cnt, cur.e.lc);
`endif
    end
    if (cyc > 3) begin
      n_chk++;
      if (sys_rst == !ready)
        n_pass++;
      else
        $display("FAIL sys_rst/ready cyc%0d got %b/%b",
                 cyc, sys_rst, ready);
    end
  end

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    fault_clr = 1'b0;
    // bring-up
    add(1,0,0,  3, 1,1,0,0, 0,0);
    add(0,0,0,  3, 1,1,0,0, 0,0);
    add(0,0,0,  1, 0,1,0,0, 0,0);
    add(0,0,0, 16, 0,1,0,0, 0,0);
    add(0,1,0, 10, 0,1,0,0, 0,0);
    add(0,1,0,  1, 0,0,1,0, 0,0);
    // lock loss in RUN
    add(0,1,0,  5, 0,0,1,0, 0,0);
    add(0,0,0,  2, 0,0,1,0, 0,0);
    add(0,0,0,  1, 1,1,0,0, 0,1);
    // timeouts to FAULT, clr ignored outside FAULT
    add(0,0,0,  3, 1,1,0,0, 0,1);
    add(0,0,0,  1, 0,1,0,0, 0,1);
    add(0,0,0, 99, 0,1,0,0, 0,1);
    add(0,0,0,  1, 1,1,0,0, 1,1);
    add(0,0,0,  3, 1,1,0,0, 1,1);
    add(0,0,0,  1, 0,1,0,0, 1,1);
    add(0,0,0, 50, 0,1,0,0, 1,1);
    add(0,0,1,  1, 0,1,0,0, 1,1);
    add(0,0,0, 48, 0,1,0,0, 1,1);
    add(0,0,0,  1, 1,1,0,1, 2,1);
    add(0,0,0,500, 1,1,0,1, 2,1);
    add(0,0,1,  1, 1,1,0,0, 0,1);
    add(0,0,0,  3, 1,1,0,0, 0,1);
    add(0,0,0,  1, 0,1,0,0, 0,1);
    // lk first seen at timeout count
    add(0,0,0, 97, 0,1,0,0, 0,1);
    add(0,1,0,  3, 0,1,0,0, 0,1);
    add(0,1,0,  7, 0,1,0,0, 0,1);
    add(0,1,0,  1, 0,0,1,0, 0,1);
    // drop, one timeout, relock
    add(0,0,0,  2, 0,0,1,0, 0,1);
    add(0,0,0,  1, 1,1,0,0, 0,2);
    add(0,0,0,  3, 1,1,0,0, 0,2);
    add(0,0,0,  1, 0,1,0,0, 0,2);
    add(0,0,0, 99, 0,1,0,0, 0,2);
    add(0,0,0,  1, 1,1,0,0, 1,2);
    add(0,0,0,  3, 1,1,0,0, 1,2);
    add(0,0,0,  1, 0,1,0,0, 1,2);
    // one-cycle glitch at stable count 5
    add(0,1,0,  3, 0,1,0,0, 1,2);
    add(0,1,0,  3, 0,1,0,0, 1,2);
    add(0,0,0,  1, 0,1,0,0, 1,2);
    add(0,1,0,  1, 0,1,0,0, 1,2);
    add(0,1,0,  1, 0,1,0,0, 1,2);
    add(0,1,0,  8, 0,1,0,0, 1,2);
    add(0,1,0,  1, 0,0,1,0, 0,2);
    // mid-sequence reset at WAIT_LOCK count 50
    add(0,0,0,  2, 0,0,1,0, 0,2);
    add(0,0,0,  1, 1,1,0,0, 0,3);
    add(0,0,0,  3, 1,1,0,0, 0,3);
    add(0,0,0,  1, 0,1,0,0, 0,3);
    add(0,0,0, 99, 0,1,0,0, 0,3);
    add(0,0,0,  1, 1,1,0,0, 1,3);
    add(0,0,0,  3, 1,1,0,0, 1,3);
    add(0,0,0,  1, 0,1,0,0, 1,3);
    add(0,0,0, 50, 0,1,0,0, 1,3);
    add(1,0,0,  1, 1,1,0,0, 0,0);
    add(0,0,0,  3, 1,1,0,0, 0,0);
    add(0,0,0,  1, 0,1,0,0, 0,0);
    add(0,0,0, 99, 0,1,0,0, 0,0);
    add(0,0,0,  1, 1,1,0,0, 1,0);

    @(posedge refclk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].r;
      pll_locked = tbl[i].p;
      fault_clr  = tbl[i].c;
      cur.cyc = cyc + tbl[i].n;
      cur.idx = i;
      cur.e   = tbl[i];
      sb.push_back(cur);
      repeat (tbl[i].n) @(posedge refclk);
      #1;
    end
    @(negedge refclk);
    #1;
    n_chk++;
    if (sb.size() == 0)
      n_pass++;
    else
      $display("FAIL sb_drain got %0d left exp 0",
               sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
